// File: rtl/kp_scanner.sv
// 4x4 matrix keypad scanner: column scan, row synchronizer, debounce and make/break
// keycode generation for the alarm-clock controller's key bus.
module kp_scanner #(
    parameter int unsigned SCAN_CYCLES  = 4,
    parameter int unsigned DEBOUNCE     = 2,
    parameter int unsigned BREAK_CYCLES = 2
) (
    input  logic       clk256,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [7:0] key,
    output logic       key_strobe
);

    localparam int unsigned CycW = $clog2(SCAN_CYCLES);
    localparam int unsigned DebW = $clog2(DEBOUNCE + 1);
    localparam int unsigned BrkW = (BREAK_CYCLES > 1) ? $clog2(BREAK_CYCLES) : 1;

    localparam logic [7:0] KpInvalid     = 8'h00;
    localparam logic [7:0] KpKeyReleased = 8'hF0;

    typedef enum logic [2:0] {
        StIdle, StDebPress, StPressed, StDebRelease, StBreak, StBreakCode
    } state_e;

    function automatic logic [7:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [7:0] code;
        case ({r, c})
            4'h0: code = 8'h69;
            4'h1: code = 8'h72;
            4'h2: code = 8'h7A;
            4'h4: code = 8'h6B;
            4'h5: code = 8'h73;
            4'h6: code = 8'h74;
            4'h8: code = 8'h6C;
            4'h9: code = 8'h75;
            4'hA: code = 8'h7D;
            4'hC: code = 8'h7C;
            4'hD: code = 8'h70;
            4'hE: code = 8'h7B;
            default: code = KpInvalid;  // A-D columns are unmapped
        endcase
        return code;
    endfunction

    logic [3:0]      row_meta_q, row_sync_q;
    logic [CycW-1:0] cyc_q, cyc_d;
    logic [1:0]      col_q, col_d;
    logic [1:0]      hits_q, hits_d;
    logic [7:0]      cand_q, cand_d;
    state_e          state_q, state_d;
    logic [7:0]      code_q, code_d;
    logic [DebW-1:0] deb_q, deb_d, deb_inc;
    logic [BrkW-1:0] brk_q, brk_d;
    logic [7:0]      key_q, key_d;
    logic            strobe_q, strobe_d;

    logic       slot_end, scan_done;
    logic [3:0] closed;
    logic [2:0] col_hits, hit_sum;
    logic [1:0] hits_sat, row_idx;
    logic [7:0] cand, result;

    assign col_n      = ~(4'b0001 << col_q);
    assign key        = key_q;
    assign key_strobe = strobe_q;

    // Scan accumulation: count closed keys (saturating at 2) and remember the lone key's code.
    always_comb begin
        slot_end  = (cyc_q == CycW'(SCAN_CYCLES - 1));
        scan_done = slot_end && (col_q == 2'd3);
        closed    = ~row_sync_q;
        col_hits  = {2'b0, closed[0]} + {2'b0, closed[1]} + {2'b0, closed[2]}
                  + {2'b0, closed[3]};
        row_idx = 2'd3;
        if (closed[2]) row_idx = 2'd2;
        if (closed[1]) row_idx = 2'd1;
        if (closed[0]) row_idx = 2'd0;
        hit_sum  = {1'b0, hits_q} + col_hits;
        hits_sat = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        cand     = (col_hits == 3'd1) ? key_map(row_idx, col_q) : cand_q;
        result   = (hits_sat == 2'd1) ? cand : KpInvalid;

        cyc_d  = slot_end ? '0 : cyc_q + CycW'(1);
        col_d  = slot_end ? col_q + 2'd1 : col_q;
        hits_d = hits_q;
        cand_d = cand_q;
        if (scan_done) begin
            hits_d = '0;
            cand_d = KpInvalid;
        end else if (slot_end) begin
            hits_d = hits_sat;
            cand_d = cand;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        deb_d    = deb_q;
        brk_d    = brk_q;
        key_d    = key_q;
        strobe_d = 1'b0;
        deb_inc  = (deb_q == DebW'(DEBOUNCE)) ? deb_q : deb_q + DebW'(1);

        case (state_q)
            StIdle: begin
                if (scan_done && result != KpInvalid) begin
                    code_d = result;
                    deb_d  = DebW'(1);
                    if (DEBOUNCE == 1) begin
                        state_d  = StPressed;
                        key_d    = result;
                        strobe_d = 1'b1;
                    end else begin
                        state_d = StDebPress;
                    end
                end
            end
            StDebPress: begin
                if (scan_done) begin
                    if (result == code_q) begin
                        deb_d = deb_inc;
                        if (deb_inc == DebW'(DEBOUNCE)) begin
                            state_d  = StPressed;
                            key_d    = code_q;
                            strobe_d = 1'b1;
                        end
                    end else begin
                        state_d = StIdle;
                        deb_d   = '0;
                    end
                end
            end
            StPressed: begin
                if (scan_done && result != code_q) begin
                    deb_d = DebW'(1);
                    if (DEBOUNCE == 1) begin
                        state_d  = StBreak;
                        key_d    = KpKeyReleased;
                        strobe_d = 1'b1;
                        brk_d    = '0;
                    end else begin
                        state_d = StDebRelease;
                    end
                end
            end
            StDebRelease: begin
                if (scan_done) begin
                    if (result != code_q) begin
                        deb_d = deb_inc;
                        if (deb_inc == DebW'(DEBOUNCE)) begin
                            state_d  = StBreak;
                            key_d    = KpKeyReleased;
                            strobe_d = 1'b1;
                            brk_d    = '0;
                        end
                    end else begin
                        state_d = StPressed;
                        deb_d   = '0;
                    end
                end
            end
            // Scan results are deliberately ignored while the break sequence plays out.
            StBreak: begin
                if (brk_q == BrkW'(BREAK_CYCLES - 1)) begin
                    state_d  = StBreakCode;
                    key_d    = code_q;
                    strobe_d = 1'b1;
                    brk_d    = '0;
                end else begin
                    brk_d = brk_q + BrkW'(1);
                end
            end
            StBreakCode: begin
                if (brk_q == BrkW'(BREAK_CYCLES - 1)) begin
                    state_d  = StIdle;
                    key_d    = KpInvalid;
                    strobe_d = 1'b1;
                    brk_d    = '0;
                    deb_d    = '0;
                    code_d   = KpInvalid;
                end else begin
                    brk_d = brk_q + BrkW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                key_d   = KpInvalid;
            end
        endcase
    end

    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
            cyc_q      <= '0;
            col_q      <= '0;
            hits_q     <= '0;
            cand_q     <= KpInvalid;
            state_q    <= StIdle;
            code_q     <= KpInvalid;
            deb_q      <= '0;
            brk_q      <= '0;
            key_q      <= KpInvalid;
            strobe_q   <= 1'b0;
        end else begin
            row_meta_q <= row_n;
            row_sync_q <= row_meta_q;
            cyc_q      <= cyc_d;
            col_q      <= col_d;
            hits_q     <= hits_d;
            cand_q     <= cand_d;
            state_q    <= state_d;
            code_q     <= code_d;
            deb_q      <= deb_d;
            brk_q      <= brk_d;
            key_q      <= key_d;
            strobe_q   <= strobe_d;
        end
    end

endmodule

// File: tb/tb_kp_scanner.sv
// Bench for kp_scanner: keypad matrix model, scan-level reference model of the key stream,
// directed and randomized press/release sequences.
module tb_kp_scanner;

    localparam int SCAN = 4;
    localparam int DEB  = 2;
    localparam int BRK  = 2;

    logic        clk256 = 1'b0;
    logic        reset  = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [7:0]  key;
    logic        key_strobe;
    logic [15:0] mask = '0;  // bit r*4+c = key at (row r, col c) closed

    always #5 clk256 = ~clk256;

    assign row_n[0] = ~|(mask[3:0]   & ~col_n);
    assign row_n[1] = ~|(mask[7:4]   & ~col_n);
    assign row_n[2] = ~|(mask[11:8]  & ~col_n);
    assign row_n[3] = ~|(mask[15:12] & ~col_n);

    kp_scanner #(
        .SCAN_CYCLES (SCAN),
        .DEBOUNCE    (DEB),
        .BREAK_CYCLES(BRK)
    ) dut (
        .clk256    (clk256),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key       (key),
        .key_strobe(key_strobe)
    );

    logic [7:0] code_tab [16] = '{8'h69, 8'h72, 8'h7A, 8'h00,
                                  8'h6B, 8'h73, 8'h74, 8'h00,
                                  8'h6C, 8'h75, 8'h7D, 8'h00,
                                  8'h7C, 8'h70, 8'h7B, 8'h00};

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Reference model: one step per full scan, emitting the key values the bus should show.
    logic [7:0] exp_seq[$];
    int         m_phase = 0;  // 0 idle, 1 confirming press, 2 held, 3 confirming release
    int         m_cnt   = 0;
    logic [7:0] m_code  = 8'h00;

    function automatic logic [7:0] scan_result(input logic [15:0] m);
        if ($countones(m) != 1) return 8'h00;
        for (int i = 0; i < 16; i++) if (m[i]) return code_tab[i];
        return 8'h00;
    endfunction

    task automatic model_scan(input logic [15:0] m);
        logic [7:0] r;
        r = scan_result(m);
        case (m_phase)
            0: if (r != 8'h00) begin m_code = r; m_cnt = 1; m_phase = 1; end
            1: if (r == m_code) begin
                   m_cnt++;
                   if (m_cnt >= DEB) begin m_phase = 2; exp_seq.push_back(m_code); end
               end else m_phase = 0;
            2: if (r != m_code) begin m_cnt = 1; m_phase = 3; end
            default: if (r != m_code) begin
                   m_cnt++;
                   if (m_cnt >= DEB) begin
                       exp_seq.push_back(8'hF0);
                       exp_seq.push_back(m_code);
                       exp_seq.push_back(8'h00);
                       m_phase = 0;
                   end
               end else m_phase = 2;
        endcase
    endtask

    // Bus monitor: records each new key value, its strobe, and the length of the run it ends.
    logic       mon_en = 1'b0;
    logic [7:0] obs_vals[$];
    logic       obs_strobe[$];
    int         obs_len[$];
    int         stray = 0;
    int         run_len = 0;
    logic [7:0] prev_key = 8'h00;

    initial begin
        forever begin
            @(negedge clk256);
            if (mon_en) begin
                if (key !== prev_key) begin
                    obs_vals.push_back(key);
                    obs_strobe.push_back(key_strobe);
                    obs_len.push_back(run_len);
                    run_len  = 1;
                    prev_key = key;
                end else begin
                    if (key_strobe !== 1'b0) stray++;
                    run_len++;
                end
            end
        end
    end

    // Apply mask at the start of the next scan so every scan sees one stable mask.
    task automatic next_scan(input logic [15:0] m);
        int n;
        n = 0;
        do begin @(negedge clk256); n++; end while (col_n !== 4'b0111 && n < 40);
        do begin @(negedge clk256); n++; end while (col_n !== 4'b1110 && n < 80);
        if (n >= 80) begin
            total++;
            fails++;
            $error("FAIL scan_align: col_n=%b after %0d clocks, required 1110 within 80", col_n, n);
        end
        mask = m;
        model_scan(m);
    endtask

    task automatic hold(input logic [15:0] m, input int scans);
        for (int i = 0; i < scans; i++) next_scan(m);
    endtask

    initial begin
        int n;
        int k1, k2;
        int nmin;

        // Reset state
        repeat (3) @(negedge clk256);
        check("rst_key", 32'(key), 32'h00);
        check("rst_col", 32'(col_n), 32'b1110);
        check("rst_strobe", 32'(key_strobe), 32'h0);
        reset = 1'b1;
        mask  = 16'h0020;  // key 5
        repeat (60) @(negedge clk256);
        check("press5_before_reset", 32'(key), 32'h73);

        // Reset mid-scan with 5 held
        repeat (5) @(posedge clk256);
        #3 reset = 1'b0;
        #1;
        check("midrst_key", 32'(key), 32'h00);
        check("midrst_col", 32'(col_n), 32'b1110);
        check("midrst_strobe", 32'(key_strobe), 32'h0);
        repeat (3) @(negedge clk256);
        check("midrst_key_held", 32'(key), 32'h00);
        reset = 1'b1;
        n = 0;
        while (key !== 8'h73 && n < 60) begin @(negedge clk256); n++; end
        check("post_reset_key", 32'(key), 32'h73);
        check("post_reset_within_51", 32'(n <= 51), 32'h1);

        mask = '0;
        repeat (80) @(negedge clk256);
        check("idle_after_release", 32'(key), 32'h00);
        @(posedge clk256);
        #1 mon_en = 1'b1;

        // Directed sequences
        hold(16'h0020, 7);                 // single press of 5
        hold(16'h0000, 3);
        hold(16'h0100, 1);                 // 7 bounces for one scan
        hold(16'h0000, 3);
        hold(16'h0003, 4);                 // 1+2
        hold(16'h0008, 4);                 // A alone
        hold(16'h4000, 4);                 // #
        hold(16'h0000, 3);
        hold(16'h0004, 4);                 // 3, then roll to 9
        hold(16'h0400, 4);
        hold(16'h0000, 3);
        hold(16'h1000, 4);                 // *
        hold(16'h0000, 3);

        // Randomized sequences
        for (int it = 0; it < 16; it++) begin
            k1 = $urandom_range(0, 15);
            k2 = (k1 + $urandom_range(1, 15)) % 16;
            case ($urandom_range(0, 3))
                0: hold(16'h0000, $urandom_range(1, 4));
                1: hold(16'(1) << k1, $urandom_range(1, 6));
                2: hold((16'(1) << k1) | (16'(1) << k2), $urandom_range(1, 4));
                default: hold(16'(1) << k1, 1);
            endcase
        end
        hold(16'h0000, 4);
        repeat (20) @(negedge clk256);
        mon_en = 1'b0;

        // Compare recorded bus activity against the model
        check("seq_len", 32'(obs_vals.size()), 32'(exp_seq.size()));
        nmin = (obs_vals.size() < exp_seq.size()) ? obs_vals.size() : exp_seq.size();
        for (int i = 0; i < nmin; i++) begin
            check($sformatf("seq[%0d]", i), 32'(obs_vals[i]), 32'(exp_seq[i]));
            check($sformatf("strobe[%0d]", i), 32'(obs_strobe[i]), 32'h1);
        end
        check("stray_strobes", 32'(stray), 32'h0);
        for (int j = 0; j < nmin; j++) begin
            if (exp_seq[j] == 8'hF0 && j + 2 < obs_len.size()) begin
                check($sformatf("f0_len[%0d]", j), 32'(obs_len[j + 1]), 32'(BRK));
                check($sformatf("brkcode_len[%0d]", j), 32'(obs_len[j + 2]), 32'(BRK));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
